stream_comp_scheduler: RTL and testbench
========================================

# stream_comp_scheduler

Self-timed scheduler for the three-mode `stream_comp` CFDF actor: setup_comp, then comp, then output. It holds the actor's current mode and evaluates that mode's enable condition from FIFO populations. When the condition holds it issues a one-cycle invoke, waits for firing complete (FC), and then adopts the actor's returned next mode. It sits between the actor's invoke/FC interface and the population counters of the actor's three input FIFOs and one output FIFO. It also counts firings and flags protocol errors.

## Interface
- `width`, 10: token width; must match the actor's `width`.
- `pop_width`, 8: width of the FIFO population and free-space inputs.
- `timeout`, 1024: maximum cycles allowed in S_WAIT before a watchdog error; must be ≥ 2.
- `clk`  in  1  clock; every register updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `run`  in  1  level-sensitive enable for scheduling new firings.
- `pop_data`  in  pop_width  token count in the data FIFO.
- `pop_length`  in  pop_width  token count in the length FIFO.
- `pop_command`  in  pop_width  token count in the command FIFO.
- `free_out`  in  pop_width  free slots in the output FIFO.
- `length_peek`  in  width  head token of the length FIFO; valid when `pop_length` > 0.
- `actor_FC`  in  1  firing-complete pulse from the actor.
- `actor_next_mode_out`  in  2  next mode reported by the actor; valid in the `actor_FC` cycle.
- `actor_invoke`  out  1  one-cycle invoke pulse to the actor.
- `actor_next_mode_in`  out  2  mode to execute; held stable from S_INVOKE until FC.
- `busy`  out  1  high whenever state ≠ S_IDLE.
- `error`  out  1  sticky error flag; cleared only by `rst`.
- `firing_count`  out  16  number of completed firings; wraps modulo 2^16.
- `cur_len`  out  width  length L captured at the last setup_comp invoke.

## Operation
- Mode encoding: SETUP_COMP = 2'b00, COMP = 2'b01, OUTPUT = 2'b10. The value 2'b11 is illegal.
- Reset values: state = S_IDLE, mode = SETUP_COMP, and all outputs 0.
- Enable conditions, per mode:
  - SETUP_COMP: `pop_length` ≥ 1 and `pop_command` ≥ 1.
  - COMP: `pop_data` ≥ `cur_len`. Compare unsigned after zero-extending both operands to max(width, pop_width). L = 0 is always enabled.
  - OUTPUT: `free_out` ≥ 1.
- FSM states and transitions:
  - S_IDLE → S_CHECK when `run` = 1.
  - S_CHECK → S_INVOKE when `run` = 1 and the current mode's enable holds.
  - S_CHECK → S_IDLE when `run` = 0.
  - S_CHECK stays in S_CHECK otherwise; enable is re-evaluated every cycle.
  - S_INVOKE → S_WAIT unconditionally. In the S_INVOKE cycle with mode = SETUP_COMP, `cur_len` ← `length_peek`.
  - S_WAIT, on `actor_FC` = 1 with a legal next mode: mode ← `actor_next_mode_out`, `firing_count` increments, then go to S_CHECK if `run` = 1, else S_IDLE.
  - S_WAIT, on `actor_FC` = 1 with `actor_next_mode_out` = 2'b11: `error` ← 1, mode is unchanged, the count still increments, next state is S_ERR.
  - S_WAIT, watchdog: counter cleared on entry and incremented each S_WAIT cycle. When it reaches `timeout` without FC: `error` ← 1, next state is S_ERR.
  - S_ERR is absorbing; only `rst` leaves it. No invokes are issued from S_ERR.
- A firing is never aborted. Dropping `run` during S_INVOKE or S_WAIT takes effect only after FC.
- An `actor_FC` seen outside S_WAIT is a protocol violation: `error` ← 1, next state is S_ERR.
- `rst` asserted mid-firing returns the block immediately to reset values. The actor must be reset in the same event.

## Timing
- `actor_invoke` is a Moore output: high exactly while state = S_INVOKE, one cycle per firing.
- Latency: `run` sampled high at edge k gives S_CHECK at k+1. If enabled, S_INVOKE, with `actor_invoke` high, follows at k+2.
- FC at edge j: the new mode is visible at j+1. The earliest next invoke is one cycle later (S_CHECK at j+1, S_INVOKE at j+2). This minimum gap is 2 cycles.
- `actor_next_mode_in` is registered. It equals the mode register and changes only on the edge after FC.
- Population inputs are sampled only in S_CHECK. Changes during S_WAIT are ignored until the next S_CHECK.
- `firing_count` and `cur_len` update on the same edge as the state change that causes them.

## Test plan
- Reset, then `run` = 1 with `pop_length` = 1 and `pop_command` = 1. Expect `actor_invoke` high for exactly 1 cycle with `actor_next_mode_in` = 00, two cycles after `run`.
- Full sequence with `length_peek` = 5, FC returning 01, then 10, then 00. Expect:
  - `cur_len` = 5.
  - The COMP invoke is withheld while `pop_data` = 4 and issued one cycle after `pop_data` = 5.
  - The OUTPUT invoke is withheld while `free_out` = 0.
  - `firing_count` = 3 at the end.
- `length_peek` = 0: expect the COMP invoke with `pop_data` = 0, 2 cycles after the setup FC.
- Drop `run` during S_WAIT: FC is still accepted, the mode updates, the state goes to S_IDLE, and no further invoke occurs.
- Fault cases, each expecting `error` = 1, `busy` = 1 and no further invokes:
  - FC with next_mode_out = 11.
  - No FC for `timeout` cycles.
  - A spurious FC in S_CHECK.
- Assert `rst` mid-S_WAIT: all outputs read 0 and mode = 00 in the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/stream_comp_scheduler_if.sv
// stream_comp_scheduler_if: run control, FIFO populations and actor invoke/FC handshake of the scheduler
interface stream_comp_scheduler_if #(
  parameter int width     = 10,
  parameter int pop_width = 8
);
  logic                 run;
  logic [pop_width-1:0] pop_data;
  logic [pop_width-1:0] pop_length;
  logic [pop_width-1:0] pop_command;
  logic [pop_width-1:0] free_out;
  logic [width-1:0]     length_peek;
  logic                 actor_FC;
  logic [1:0]           actor_next_mode_out;
  logic                 actor_invoke;
  logic [1:0]           actor_next_mode_in;
  logic                 busy;
  logic                 error;
  logic [15:0]          firing_count;
  logic [width-1:0]     cur_len;
  modport master (
    input  run, pop_data, pop_length, pop_command, free_out, length_peek, actor_FC, actor_next_mode_out,
    output actor_invoke, actor_next_mode_in, busy, error, firing_count, cur_len
  );
  modport slave (
    output run, pop_data, pop_length, pop_command, free_out, length_peek, actor_FC, actor_next_mode_out,
    input  actor_invoke, actor_next_mode_in, busy, error, firing_count, cur_len
  );
endinterface

// File: rtl/stream_comp_scheduler.sv
// stream_comp_scheduler: self-timed CFDF scheduler for the three-mode stream_comp actor
module stream_comp_scheduler #(
  parameter int width     = 10,
  parameter int pop_width = 8,
  parameter int timeout   = 1024
) (
  input logic                     clk,
  input logic                     rst,
  stream_comp_scheduler_if.master b
);
  localparam int MW = width > pop_width ? width : pop_width;
  localparam int WW = $clog2(timeout + 1);
  localparam logic [1:0] SETUP_COMP = 2'b00;
  localparam logic [1:0] COMP       = 2'b01;
  localparam logic [1:0] ILLEGAL    = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_INVOKE, S_WAIT, S_ERR} state_t;
  state_t           r_state;
  logic [1:0]       r_mode;
  logic             r_invoke;
  logic             r_busy;
  logic             r_error;
  logic [15:0]      r_count;
  logic [width-1:0] r_cur_len;
  logic [WW-1:0]    r_wd;
  logic             w_en;
  // enable condition of the current mode, evaluated from live FIFO populations
  always_comb w_en = (r_mode == SETUP_COMP) ? (b.pop_length != '0 && b.pop_command != '0) :
                     (r_mode == COMP) ? (MW'(b.pop_data) >= MW'(r_cur_len)) :
                     (b.free_out != '0);
  // scheduler FSM with registered invoke/busy/error and firing bookkeeping
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= S_IDLE;
      r_mode    <= SETUP_COMP;
      r_invoke  <= 1'b0;
      r_busy    <= 1'b0;
      r_error   <= 1'b0;
      r_count   <= '0;
      r_cur_len <= '0;
      r_wd      <= '0;
    end else begin
      r_invoke <= 1'b0;
      case (r_state)
        S_IDLE:
          if (b.actor_FC) begin
            r_state <= S_ERR;
            r_error <= 1'b1;
            r_busy  <= 1'b1;
          end else if (b.run) begin
            r_state <= S_CHECK;
            r_busy  <= 1'b1;
          end
        S_CHECK:
          if (b.actor_FC) begin
            r_state <= S_ERR;
            r_error <= 1'b1;
          end else if (!b.run) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_en) begin
            r_state  <= S_INVOKE;
            r_invoke <= 1'b1;
          end
        S_INVOKE:
          if (b.actor_FC) begin
            r_state <= S_ERR;
            r_error <= 1'b1;
          end else begin
            r_state <= S_WAIT;
            r_wd    <= '0;
            if (r_mode == SETUP_COMP) r_cur_len <= b.length_peek;
          end
        S_WAIT:
          if (b.actor_FC) begin
            r_count <= r_count + 16'd1;
            if (b.actor_next_mode_out == ILLEGAL) begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end else begin
              r_mode  <= b.actor_next_mode_out;
              r_state <= b.run ? S_CHECK : S_IDLE;
              r_busy  <= b.run;
            end
          end else if (r_wd == WW'(timeout - 1)) begin
            r_state <= S_ERR;
            r_error <= 1'b1;
          end else
            r_wd <= r_wd + 1'b1;
        default: r_state <= S_ERR;
      endcase
    end
  assign b.actor_invoke       = r_invoke;
  assign b.actor_next_mode_in = r_mode;
  assign b.busy               = r_busy;
  assign b.error              = r_error;
  assign b.firing_count       = r_count;
  assign b.cur_len            = r_cur_len;
endmodule

// File: tb/tb_stream_comp_scheduler.sv
// tb_stream_comp_scheduler: directed scenarios plus randomized firings against a transaction-level model
module tb_stream_comp_scheduler;
  localparam int T = 20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  stream_comp_scheduler_if #(.width(10), .pop_width(8)) b();
  stream_comp_scheduler #(.width(10), .pop_width(8), .timeout(T)) dut (.clk(clk), .rst(rst), .b(b));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
  function automatic bit enabled(int mode, int len, int pd, int pl, int pc, int fo);
    if (mode == 0) return pl >= 1 && pc >= 1;
    if (mode == 1) return pd >= len;
    return fo >= 1;
  endfunction
  task automatic do_reset();
    rst = 1'b1;
    b.run = 1'b0;
    b.pop_data = '0;
    b.pop_length = '0;
    b.pop_command = '0;
    b.free_out = '0;
    b.length_peek = '0;
    b.actor_FC = 1'b0;
    b.actor_next_mode_out = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic start_setup(input int lp);
    b.length_peek = 10'(lp);
    b.pop_length = 8'd1;
    b.pop_command = 8'd1;
    b.run = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic fc(input logic [1:0] nm);
    b.actor_FC = 1'b1;
    b.actor_next_mode_out = nm;
    @(negedge clk);
    b.actor_FC = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    total++; if (b.actor_invoke !== 1'b0) begin bad++; $display("FAIL reset_invoke got=%0b exp=0", b.actor_invoke); end
    total++; if (b.actor_next_mode_in !== 2'b00) begin bad++; $display("FAIL reset_mode got=%0d exp=0", b.actor_next_mode_in); end
    total++; if ({b.busy, b.error} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {b.busy, b.error}); end
    total++; if (b.firing_count !== 16'd0 || b.cur_len !== 10'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", b.firing_count, b.cur_len); end
  endtask
  task automatic test_basic_invoke();
    do_reset();
    b.pop_length = 8'd1;
    b.pop_command = 8'd1;
    b.run = 1'b1;
    @(negedge clk);
    total++; if (b.actor_invoke !== 1'b0 || b.busy !== 1'b1) begin bad++; $display("FAIL basic_check got=%0b%0b exp=01", b.actor_invoke, b.busy); end
    @(negedge clk);
    total++; if (b.actor_invoke !== 1'b1 || b.actor_next_mode_in !== 2'b00) begin bad++; $display("FAIL basic_invoke got=%0b/%0d exp=1/0", b.actor_invoke, b.actor_next_mode_in); end
    @(negedge clk);
    total++; if (b.actor_invoke !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got=%0b exp=0", b.actor_invoke); end
  endtask
  task automatic test_full_sequence();
    do_reset();
    start_setup(5);
    total++; if (b.actor_invoke !== 1'b1) begin bad++; $display("FAIL seq_setup_invoke got=%0b exp=1", b.actor_invoke); end
    @(negedge clk);
    total++; if (b.cur_len !== 10'd5) begin bad++; $display("FAIL seq_cur_len got=%0d exp=5", b.cur_len); end
    b.pop_data = 8'd4;
    fc(2'b01);
    total++; if (b.actor_next_mode_in !== 2'b01) begin bad++; $display("FAIL seq_mode_comp got=%0d exp=1", b.actor_next_mode_in); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (b.actor_invoke !== 1'b0) begin bad++; $display("FAIL seq_comp_withheld got=%0b exp=0", b.actor_invoke); end
    end
    b.pop_data = 8'd5;
    @(negedge clk);
    total++; if (b.actor_invoke !== 1'b1 || b.actor_next_mode_in !== 2'b01) begin bad++; $display("FAIL seq_comp_invoke got=%0b/%0d exp=1/1", b.actor_invoke, b.actor_next_mode_in); end
    @(negedge clk);
    b.free_out = 8'd0;
    fc(2'b10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (b.actor_invoke !== 1'b0) begin bad++; $display("FAIL seq_out_withheld got=%0b exp=0", b.actor_invoke); end
    end
    b.free_out = 8'd1;
    @(negedge clk);
    total++; if (b.actor_invoke !== 1'b1 || b.actor_next_mode_in !== 2'b10) begin bad++; $display("FAIL seq_out_invoke got=%0b/%0d exp=1/2", b.actor_invoke, b.actor_next_mode_in); end
    @(negedge clk);
    fc(2'b00);
    total++; if (b.firing_count !== 16'd3) begin bad++; $display("FAIL seq_count got=%0d exp=3", b.firing_count); end
    total++; if (b.actor_next_mode_in !== 2'b00 || b.busy !== 1'b1) begin bad++; $display("FAIL seq_end_state got=%0d/%0b exp=0/1", b.actor_next_mode_in, b.busy); end
  endtask
  task automatic test_zero_len();
    do_reset();
    start_setup(0);
    @(negedge clk);
    fc(2'b01);
    total++; if (b.actor_invoke !== 1'b0) begin bad++; $display("FAIL zero_len_early got=%0b exp=0", b.actor_invoke); end
    @(negedge clk);
    total++; if (b.actor_invoke !== 1'b1 || b.cur_len !== 10'd0) begin bad++; $display("FAIL zero_len_invoke got=%0b/%0d exp=1/0", b.actor_invoke, b.cur_len); end
  endtask
  task automatic test_run_drop();
    do_reset();
    start_setup(3);
    @(negedge clk);
    b.run = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (b.busy !== 1'b1) begin bad++; $display("FAIL drop_busy_wait got=%0b exp=1", b.busy); end
    b.pop_data = 8'd50;
    fc(2'b01);
    total++; if (b.actor_next_mode_in !== 2'b01 || b.busy !== 1'b0 || b.firing_count !== 16'd1) begin bad++; $display("FAIL drop_fc got=%0d/%0b/%0d exp=1/0/1", b.actor_next_mode_in, b.busy, b.firing_count); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (b.actor_invoke !== 1'b0 || b.busy !== 1'b0) begin bad++; $display("FAIL drop_idle got=%0b/%0b exp=0/0", b.actor_invoke, b.busy); end
    end
  endtask
  task automatic check_dead(input string name);
    b.run = 1'b1;
    b.pop_length = 8'd1;
    b.pop_command = 8'd1;
    b.pop_data = 8'd200;
    b.free_out = 8'd5;
    total++; if (b.error !== 1'b1 || b.busy !== 1'b1) begin bad++; $display("FAIL %s_flags got=%0b/%0b exp=1/1", name, b.error, b.busy); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (b.actor_invoke !== 1'b0 || b.error !== 1'b1) begin bad++; $display("FAIL %s_absorb got=%0b/%0b exp=0/1", name, b.actor_invoke, b.error); end
    end
  endtask
  task automatic test_bad_mode();
    do_reset();
    start_setup(2);
    @(negedge clk);
    fc(2'b11);
    total++; if (b.actor_next_mode_in !== 2'b00 || b.firing_count !== 16'd1) begin bad++; $display("FAIL bad_mode_state got=%0d/%0d exp=0/1", b.actor_next_mode_in, b.firing_count); end
    check_dead("bad_mode");
  endtask
  task automatic test_timeout();
    int n;
    do_reset();
    start_setup(2);
    n = 0;
    while (b.error !== 1'b1 && n < T + 10) begin
      @(negedge clk);
      n++;
    end
    total++; if (n != T + 1) begin bad++; $display("FAIL timeout_cycles got=%0d exp=%0d", n, T + 1); end
    check_dead("timeout");
  endtask
  task automatic test_spurious_fc();
    do_reset();
    b.run = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (b.error !== 1'b0 || b.busy !== 1'b1) begin bad++; $display("FAIL spur_pre got=%0b/%0b exp=0/1", b.error, b.busy); end
    fc(2'b01);
    check_dead("spurious");
  endtask
  task automatic test_rst_mid_wait();
    do_reset();
    start_setup(7);
    @(negedge clk);
    b.pop_data = 8'd7;
    fc(2'b01);
    @(negedge clk);
    @(negedge clk);
    total++; if (b.firing_count !== 16'd1 || b.cur_len !== 10'd7 || b.busy !== 1'b1) begin bad++; $display("FAIL rst_pre got=%0d/%0d/%0b exp=1/7/1", b.firing_count, b.cur_len, b.busy); end
    #1 rst = 1'b1;
    #1;
    total++; if ({b.actor_invoke, b.busy, b.error} !== 3'b000 || b.actor_next_mode_in !== 2'b00) begin bad++; $display("FAIL rst_async_flags got=%b/%0d exp=000/0", {b.actor_invoke, b.busy, b.error}, b.actor_next_mode_in); end
    total++; if (b.firing_count !== 16'd0 || b.cur_len !== 10'd0) begin bad++; $display("FAIL rst_async_counts got=%0d/%0d exp=0/0", b.firing_count, b.cur_len); end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_random();
    bit [1:0]  m_mode;
    int        m_len;
    bit [15:0] m_cnt;
    bit        en;
    bit        got;
    int        n;
    int        lp;
    bit [1:0]  nm;
    m_mode = 2'b00;
    m_len = 0;
    m_cnt = '0;
    do_reset();
    b.run = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 60; f++) begin
      lp = $urandom_range(0, 12);
      b.length_peek = 10'(lp);
      got = 1'b0;
      n = 0;
      while (!got && n < 60) begin
        b.pop_data = 8'($urandom_range(0, 15));
        b.pop_length = 8'($urandom_range(0, 2));
        b.pop_command = 8'($urandom_range(0, 2));
        b.free_out = 8'($urandom_range(0, 2));
        en = enabled(m_mode, m_len, b.pop_data, b.pop_length, b.pop_command, b.free_out);
        @(negedge clk);
        n++;
        total++; if (b.actor_invoke !== en) begin bad++; $display("FAIL rand_invoke firing=%0d got=%0b exp=%0b", f, b.actor_invoke, en); end
        got = en;
      end
      if (!got) begin
        total++; bad++; $display("FAIL rand_stall firing=%0d got=no_invoke exp=invoke", f);
        return;
      end
      total++; if (b.actor_next_mode_in !== m_mode) begin bad++; $display("FAIL rand_mode_in got=%0d exp=%0d", b.actor_next_mode_in, m_mode); end
      if (m_mode == 2'b00) m_len = lp;
      repeat ($urandom_range(1, 3)) begin
        b.pop_data = 8'($urandom_range(0, 15));
        @(negedge clk);
        total++; if (b.actor_invoke !== 1'b0) begin bad++; $display("FAIL rand_wait_invoke got=%0b exp=0", b.actor_invoke); end
      end
      nm = 2'($urandom_range(0, 2));
      fc(nm);
      m_mode = nm;
      m_cnt++;
      total++; if (b.actor_next_mode_in !== m_mode || b.firing_count !== m_cnt) begin bad++; $display("FAIL rand_fc got=%0d/%0d exp=%0d/%0d", b.actor_next_mode_in, b.firing_count, m_mode, m_cnt); end
      total++; if (b.cur_len !== 10'(m_len) || b.error !== 1'b0) begin bad++; $display("FAIL rand_len got=%0d/%0b exp=%0d/0", b.cur_len, b.error, m_len); end
    end
  endtask
  initial begin
    test_reset();
    test_basic_invoke();
    test_full_sequence();
    test_zero_len();
    test_run_drop();
    test_bad_mode();
    test_timeout();
    test_spurious_fc();
    test_rst_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
